// File: rtl/dac_stream_out_if.sv
// AXI4-Stream carrying one two-lane sample pair per beat: [15:0] lane A, [31:16] lane B.
interface dac_stream_out_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/dac_stream_out.sv
// Streaming DAC driver: AXI-Stream -> FWFT FIFO -> one pair per rate_div clocks to the DAC pins.
// Define DAC_SATURATE_EN to clamp out-of-range samples instead of wrapping them.
module dac_stream_out #(
  parameter int unsigned DAC_DATA_WIDTH  = 14,
  parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  dac_stream_out_if.slave             s_axis,
  input  logic                        enable,
  input  logic [15:0]                 rate_div,
  output logic [DAC_DATA_WIDTH-1:0]   dac_dat_a,
  output logic [DAC_DATA_WIDTH-1:0]   dac_dat_b,
  output logic                        dac_valid,
  output logic [15:0]                 underrun_cnt,
  output logic [FIFO_DEPTH_LOG2:0]    fifo_level
);

  localparam int unsigned Depth = 2 ** FIFO_DEPTH_LOG2;
  localparam int unsigned W     = DAC_DATA_WIDTH;

  localparam logic [W-1:0]               Midscale = {1'b0, {(W-1){1'b1}}};
  localparam logic [FIFO_DEPTH_LOG2:0]   LvlFull  = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};
  localparam logic [FIFO_DEPTH_LOG2:0]   LvlOne   = 1;
  localparam logic [FIFO_DEPTH_LOG2-1:0] PtrOne   = 1;

  // Board DAC takes an inverted offset code: {sign, ~magnitude bits}.
  function automatic logic [W-1:0] to_code(input logic [15:0] x);
    logic [W-1:0] s;
    s = x[W-1:0];
`ifdef DAC_SATURATE_EN
    if (x[15:W-1] != {(17-W){x[15]}}) begin
      s = x[15] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
`endif
    return {s[W-1], ~s[W-2:0]};
  endfunction

  logic [31:0]                mem [Depth];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_LOG2:0]   level_q, level_d;
  logic [15:0]                cnt_q, cnt_d;
  logic [W-1:0]               dat_a_q, dat_a_d;
  logic [W-1:0]               dat_b_q, dat_b_d;
  logic                       valid_q, valid_d;
  logic [15:0]                under_q, under_d;
  logic                       ready_q;

  logic        full, empty, push, pop, tick;
  logic [31:0] head;

  always_comb begin
    full          = (level_q == LvlFull);
    empty         = (level_q == '0);
    s_axis.tready = ready_q & ~full;
    push          = s_axis.tvalid & s_axis.tready;
    tick          = enable & (cnt_q == 16'd0);
    // Emptiness is judged on the registered level, so a same-cycle push cannot rescue a tick.
    pop           = tick & ~empty;
    head          = mem[rd_ptr_q];
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrOne : rd_ptr_q;
    level_d  = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LvlOne;
      2'b01:   level_d = level_q - LvlOne;
      default: level_d = level_q;
    endcase

    cnt_d = 16'd0;
    if (enable) begin
      if (tick) begin
        cnt_d = (rate_div <= 16'd1) ? 16'd0 : rate_div - 16'd1;
      end else begin
        cnt_d = cnt_q - 16'd1;
      end
    end

    dat_a_d = dat_a_q;
    dat_b_d = dat_b_q;
    valid_d = 1'b0;
    under_d = under_q;
    if (!enable) begin
      dat_a_d = Midscale;
      dat_b_d = Midscale;
    end else if (pop) begin
      dat_a_d = to_code(head[15:0]);
      dat_b_d = to_code(head[31:16]);
      valid_d = 1'b1;
    end else if (tick && under_q != 16'hFFFF) begin
      under_d = under_q + 16'd1;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_ptr_q] <= s_axis.tdata;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ready_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cnt_q    <= 16'd0;
      dat_a_q  <= Midscale;
      dat_b_q  <= Midscale;
      valid_q  <= 1'b0;
      under_q  <= 16'd0;
    end else begin
      ready_q  <= 1'b1;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      dat_a_q  <= dat_a_d;
      dat_b_q  <= dat_b_d;
      valid_q  <= valid_d;
      under_q  <= under_d;
    end
  end

  assign dac_dat_a    = dat_a_q;
  assign dac_dat_b    = dat_b_q;
  assign dac_valid    = valid_q;
  assign underrun_cnt = under_q;
  assign fifo_level   = level_q;

endmodule

// File: tb/tb_dac_stream_out.sv
// Directed bench for dac_stream_out: conversion vector table plus hand-written pacing,
// priming, streaming and reset sequences.
module tb_dac_stream_out;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] rate_div = 16'd1;
  logic [13:0] dac_dat_a, dac_dat_b;
  logic        dac_valid;
  logic [15:0] underrun_cnt;
  logic [2:0]  fifo_level;

  int checks = 0;
  int failures = 0;

  dac_stream_out_if s_axis ();

  dac_stream_out #(
    .DAC_DATA_WIDTH (14),
    .FIFO_DEPTH_LOG2(2)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .s_axis      (s_axis),
    .enable      (enable),
    .rate_div    (rate_div),
    .dac_dat_a   (dac_dat_a),
    .dac_dat_b   (dac_dat_b),
    .dac_valid   (dac_valid),
    .underrun_cnt(underrun_cnt),
    .fifo_level  (fifo_level)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [13:0] code_a;
    logic [13:0] code_b;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the transfer edge.
  task automatic push(input logic [31:0] d);
    int n;
    n = 0;
    s_axis.tdata  = d;
    s_axis.tvalid = 1'b1;
    while (!s_axis.tready && n < 20) begin
      @(negedge aclk);
      n++;
    end
    if (n == 20) begin
      chk("push_timeout", 32'd1, 32'd0);
    end
    @(posedge aclk);
    @(negedge aclk);
    s_axis.tvalid = 1'b0;
  endtask

  function automatic logic [31:0] word(input int i);
    return {16'(i + 100), 16'(i)};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          idx;
    logic        rdy;
    logic        exp_v;
    logic [15:0] exp_u;

    vecs[0] = '{a: 16'h0000, b: 16'h0001, code_a: 14'h1FFF, code_b: 14'h1FFE};
    vecs[1] = '{a: 16'h1FFF, b: 16'hE000, code_a: 14'h0000, code_b: 14'h3FFF};
    vecs[2] = '{a: 16'hFFFF, b: 16'h0100, code_a: 14'h2000, code_b: 14'h1EFF};
`ifdef DAC_SATURATE_EN
    vecs[3] = '{a: 16'h7FFF, b: 16'h8000, code_a: 14'h0000, code_b: 14'h3FFF};
    vecs[4] = '{a: 16'h2000, b: 16'hDFFF, code_a: 14'h0000, code_b: 14'h3FFF};
`else
    vecs[3] = '{a: 16'h7FFF, b: 16'h8000, code_a: 14'h2000, code_b: 14'h1FFF};
    vecs[4] = '{a: 16'h2000, b: 16'hDFFF, code_a: 14'h3FFF, code_b: 14'h0000};
`endif

    s_axis.tdata  = 32'd0;
    s_axis.tvalid = 1'b0;

    // Reset state
    repeat (2) @(negedge aclk);
    chk("rst_dat_a", 32'(dac_dat_a), 32'h1FFF);
    chk("rst_dat_b", 32'(dac_dat_b), 32'h1FFF);
    chk("rst_valid", 32'(dac_valid), 32'd0);
    chk("rst_under", 32'(underrun_cnt), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_tready", 32'(s_axis.tready), 32'd0);
    aresetn = 1'b1;
    #1 chk("tready_after_release", 32'(s_axis.tready), 32'd0);
    @(negedge aclk);
    chk("tready_one_clock_later", 32'(s_axis.tready), 32'd1);

    // Priming with playback disabled: fifth word must be refused
    for (int j = 1; j <= 4; j++) push({16'(j), 16'(j)});
    s_axis.tdata  = 32'h0005_0005;
    s_axis.tvalid = 1'b1;
    #1 chk("full_tready", 32'(s_axis.tready), 32'd0);
    chk("full_level", 32'(fifo_level), 32'd4);
    @(negedge aclk);
    chk("full_level_hold", 32'(fifo_level), 32'd4);
    chk("prime_dat_a", 32'(dac_dat_a), 32'h1FFF);
    chk("prime_dat_b", 32'(dac_dat_b), 32'h1FFF);
    chk("prime_under", 32'(underrun_cnt), 32'd0);
    s_axis.tvalid = 1'b0;

    // rate_div=4: strobes on edges 1,5,9,13, underruns on 17,21
    rate_div = 16'd4;
    enable   = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      @(negedge aclk);
      exp_v = (i % 4 == 1) && (i <= 13);
      exp_u = (i >= 21) ? 16'd2 : (i >= 17) ? 16'd1 : 16'd0;
      chk("pace_valid", 32'(dac_valid), 32'(exp_v));
      chk("pace_under", 32'(underrun_cnt), 32'(exp_u));
    end
    chk("pace_hold_a", 32'(dac_dat_a), 32'h1FFB);
    chk("pace_hold_b", 32'(dac_dat_b), 32'h1FFB);
    chk("pace_level", 32'(fifo_level), 32'd0);
    enable = 1'b0;
    @(negedge aclk);
    chk("disable_mid_a", 32'(dac_dat_a), 32'h1FFF);
    chk("disable_valid", 32'(dac_valid), 32'd0);
    repeat (3) @(negedge aclk);
    chk("disable_under_frozen", 32'(underrun_cnt), 32'd2);

    // rate_div=1 with empty FIFO: one underrun per clock
    rate_div = 16'd1;
    enable   = 1'b1;
    repeat (3) @(negedge aclk);
    chk("under_per_clock", 32'(underrun_cnt), 32'd5);
    enable = 1'b0;
    @(negedge aclk);
    chk("under_frozen2", 32'(underrun_cnt), 32'd5);

    // Code conversion table: one pair popped per vector
    foreach (vecs[v]) begin
      push({vecs[v].b, vecs[v].a});
      enable = 1'b1;
      @(negedge aclk);
      chk("vec_valid", 32'(dac_valid), 32'd1);
      chk("vec_code_a", 32'(dac_dat_a), 32'(vecs[v].code_a));
      chk("vec_code_b", 32'(dac_dat_b), 32'(vecs[v].code_b));
      enable = 1'b0;
      @(negedge aclk);
      chk("vec_mid_a", 32'(dac_dat_a), 32'h1FFF);
      chk("vec_valid_off", 32'(dac_valid), 32'd0);
    end
    chk("vec_under", 32'(underrun_cnt), 32'd5);

    // Continuous streaming at rate_div=1 after one word of fill
    idx           = 0;
    s_axis.tdata  = word(0);
    s_axis.tvalid = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      rdy = s_axis.tready;
      @(posedge aclk);
      if (rdy) idx++;
      @(negedge aclk);
      s_axis.tdata = word(idx);
      if (cyc == 0) begin
        enable = 1'b1;
        chk("stream_fill", 32'(fifo_level), 32'd1);
      end else begin
        chk("stream_valid", 32'(dac_valid), 32'd1);
        chk("stream_a", 32'(dac_dat_a), 32'(14'h1FFF - 14'(cyc - 1)));
        chk("stream_b", 32'(dac_dat_b), 32'(14'h1FFF - 14'(cyc - 1 + 100)));
        chk("stream_level", 32'(fifo_level), 32'd1);
        chk("stream_under", 32'(underrun_cnt), 32'd5);
      end
    end
    s_axis.tvalid = 1'b0;
    enable        = 1'b0;

    // Reset mid-playback with three entries queued
    push(word(50));
    push(word(51));
    chk("pre_rst_level3", 32'(fifo_level), 32'd3);
    rate_div = 16'd100;
    enable   = 1'b1;
    @(negedge aclk);
    chk("pre_rst_pop_a", 32'(dac_dat_a), 32'(14'h1FFF - 14'd29));
    chk("pre_rst_level2", 32'(fifo_level), 32'd2);
    push(word(52));
    chk("pre_rst_level", 32'(fifo_level), 32'd3);
    chk("pre_rst_under", 32'(underrun_cnt), 32'd5);
    #2 aresetn = 1'b0;
    enable = 1'b0;
    #1;
    chk("async_rst_a", 32'(dac_dat_a), 32'h1FFF);
    chk("async_rst_b", 32'(dac_dat_b), 32'h1FFF);
    chk("async_rst_valid", 32'(dac_valid), 32'd0);
    chk("async_rst_level", 32'(fifo_level), 32'd0);
    chk("async_rst_under", 32'(underrun_cnt), 32'd0);
    chk("async_rst_tready", 32'(s_axis.tready), 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    #1 chk("rerelease_tready", 32'(s_axis.tready), 32'd0);
    @(negedge aclk);
    chk("rerelease_tready_up", 32'(s_axis.tready), 32'd1);
    chk("rerelease_level", 32'(fifo_level), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
